// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX skid-buffered pipeline stage:
// occupancy state encoding and default datapath widths.
package id_ex_pkg;

   localparam int XLEN_DEF       = 32'd32;
   localparam int ALU_CTRL_W_DEF = 32'd5;
   localparam int CTRL_W         = 32'd4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/id_ex_skid_stage_if.sv
// Handshake and payload bundle between the ID stage, the skid stage and EX.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface id_ex_skid_stage_if
   import id_ex_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  flush;
   logic                  mem_to_reg;
   logic                  mem_write;
   logic                  alu_src;
   logic                  reg_write;
   logic [ALU_CTRL_W-1:0] alu_control;
   logic [XLEN-1:0]       pc;
   logic [XLEN-1:0]       rd1;
   logic [XLEN-1:0]       rd2;
   logic [XLEN-1:0]       imm;
   logic                  out_valid;
   logic                  out_ready;
   logic                  mem_to_reg_q;
   logic                  mem_write_q;
   logic                  alu_src_q;
   logic                  reg_write_q;
   logic [ALU_CTRL_W-1:0] alu_control_q;
   logic [XLEN-1:0]       pc_q;
   logic [XLEN-1:0]       rd1_q;
   logic [XLEN-1:0]       rd2_q;
   logic [XLEN-1:0]       imm_q;
   logic [XLEN-1:0]       branch_target_q;

   modport slave (
      input  in_valid, flush, mem_to_reg, mem_write, alu_src, reg_write,
             alu_control, pc, rd1, rd2, imm, out_ready,
      output in_ready, out_valid, mem_to_reg_q, mem_write_q, alu_src_q,
             reg_write_q, alu_control_q, pc_q, rd1_q, rd2_q, imm_q,
             branch_target_q
   );

   modport master (
      output in_valid, flush, mem_to_reg, mem_write, alu_src, reg_write,
             alu_control, pc, rd1, rd2, imm, out_ready,
      input  in_ready, out_valid, mem_to_reg_q, mem_write_q, alu_src_q,
             reg_write_q, alu_control_q, pc_q, rd1_q, rd2_q, imm_q,
             branch_target_q
   );
endinterface

// File: rtl/id_ex_payload_reg.sv
// Load-enable register holding one packed ID/EX payload
// {ctrl, alu_control, pc, rd1, rd2, imm, branch_target}.
module id_ex_payload_reg
   import id_ex_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     load,
   input  logic [CTRL_W+ALU_CTRL_W+5*XLEN-1:0]      d,
   output logic [CTRL_W+ALU_CTRL_W+5*XLEN-1:0]      q
);

   // Payload storage: cleared by reset, written only when loaded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q <= {(CTRL_W+ALU_CTRL_W+5*XLEN){1'b0}};
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with a one-entry skid buffer: full throughput,
// registered in_ready, FIFO order, flush kill and side-effect-free bubbles.
module id_ex_skid_stage
   import id_ex_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int ALU_CTRL_W = ALU_CTRL_W_DEF
) (
   input logic               clk,
   input logic               rst,
   id_ex_skid_stage_if.slave bus
);

   localparam int PW = CTRL_W + ALU_CTRL_W + 5 * XLEN;

   state_e          state_r;
   state_e          next_state_s;
   logic            in_ready_r;
   logic            out_valid_r;
   logic            accept_s;
   logic            load_main_s;
   logic            load_skid_s;
   logic            main_from_skid_s;
   logic            main_mw_s;
   logic            main_rw_s;
   logic [PW-1:0]   in_pl_s;
   logic [PW-1:0]   main_d_s;
   logic [PW-1:0]   main_q_s;
   logic [PW-1:0]   skid_q_s;

   // branch_target is fixed at capture; the sum is XLEN wide so the carry drops
   assign in_pl_s  = {bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write,
                      bus.alu_control, bus.pc, bus.rd1, bus.rd2, bus.imm,
                      bus.pc + bus.imm};
   assign accept_s = bus.in_valid & in_ready_r;
   assign main_d_s = main_from_skid_s ? skid_q_s : in_pl_s;

   // Occupancy state and the registered handshake flags derived from it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= EMPTY;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         in_ready_r  <= (next_state_s != TWO);
         out_valid_r <= (next_state_s != EMPTY);
      end
   end

   // Next-state and register load selection; flush overrides all handshakes.
   always_comb begin
      next_state_s     = state_r;
      load_main_s      = 1'b0;
      load_skid_s      = 1'b0;
      main_from_skid_s = 1'b0;
      if (bus.flush) begin
         next_state_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (accept_s) begin
                  load_main_s  = 1'b1;
                  next_state_s = ONE;
               end else begin
                  next_state_s = EMPTY;
               end
            end
            ONE: begin
               if (accept_s && bus.out_ready) begin
                  load_main_s  = 1'b1;
                  next_state_s = ONE;
               end else if (accept_s) begin
                  load_skid_s  = 1'b1;
                  next_state_s = TWO;
               end else if (bus.out_ready) begin
                  next_state_s = EMPTY;
               end else begin
                  next_state_s = ONE;
               end
            end
            TWO: begin
               if (bus.out_ready) begin
                  load_main_s      = 1'b1;
                  main_from_skid_s = 1'b1;
                  next_state_s     = ONE;
               end else begin
                  next_state_s = TWO;
               end
            end
            default: begin
               next_state_s = EMPTY;
            end
         endcase
      end
   end

   id_ex_payload_reg #(.XLEN(XLEN), .ALU_CTRL_W(ALU_CTRL_W)) u_main (
      .clk  (clk),
      .rst  (rst),
      .load (load_main_s),
      .d    (main_d_s),
      .q    (main_q_s)
   );

   id_ex_payload_reg #(.XLEN(XLEN), .ALU_CTRL_W(ALU_CTRL_W)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (load_skid_s),
      .d    (in_pl_s),
      .q    (skid_q_s)
   );

   assign {bus.mem_to_reg_q, main_mw_s, bus.alu_src_q, main_rw_s,
           bus.alu_control_q, bus.pc_q, bus.rd1_q, bus.rd2_q, bus.imm_q,
           bus.branch_target_q} = main_q_s;

   // A bubble must never write memory or the register file.
   assign bus.mem_write_q = main_mw_s & out_valid_r;
   assign bus.reg_write_q = main_rw_s & out_valid_r;
   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed, table-driven bench for id_ex_skid_stage plus hand-written
// sequences for drain ordering and reset in the full state.
module tb_id_ex_skid_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ex_skid_stage_if #(.XLEN(32), .ALU_CTRL_W(5)) bus();

   id_ex_skid_stage #(.XLEN(32), .ALU_CTRL_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        r, iv, fl, ordy;
      logic [31:0] pc, imm;
      logic [3:0]  ctl;
      logic [4:0]  ac;
      logic        e_ir, e_ov;
      logic [31:0] e_pc, e_bt;
      logic [3:0]  e_ctl;
      logic [4:0]  e_ac;
   } vec_t;

   vec_t        vecs[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] got[$];

   task automatic add(input logic r, iv, fl, ordy, input logic [31:0] pc, imm,
                      input logic [3:0] ctl, input logic [4:0] ac,
                      input logic e_ir, e_ov, input logic [31:0] e_pc, e_bt,
                      input logic [3:0] e_ctl, input logic [4:0] e_ac);
      vec_t v;
      v.r = r; v.iv = iv; v.fl = fl; v.ordy = ordy; v.pc = pc; v.imm = imm;
      v.ctl = ctl; v.ac = ac; v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc;
      v.e_bt = e_bt; v.e_ctl = e_ctl; v.e_ac = e_ac;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, iv, fl, ordy, input logic [31:0] pc, imm,
                        input logic [3:0] ctl, input logic [4:0] ac);
      rst             = r;
      bus.in_valid    = iv;
      bus.flush       = fl;
      bus.out_ready   = ordy;
      bus.pc          = pc;
      bus.imm         = imm;
      bus.rd1         = pc + 32'd1;
      bus.rd2         = pc + 32'd2;
      {bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write} = ctl;
      bus.alu_control = ac;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ctl_q();
      return {bus.mem_to_reg_q, bus.mem_write_q, bus.alu_src_q, bus.reg_write_q};
   endfunction

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0);

      //   r    iv   fl   ordy pc            imm          ctl   ac     ir   ov   e_pc          e_bt          ectl  eac
      // reset held with traffic, then release
      add(1'b0,1'b1,1'b0,1'b0,32'h100,      32'h20,      4'hF, 5'd1,  1'b0,1'b0,32'h0,        32'h0,        4'h0, 5'd0);
      add(1'b0,1'b1,1'b0,1'b0,32'h100,      32'h20,      4'hF, 5'd1,  1'b0,1'b0,32'h0,        32'h0,        4'h0, 5'd0);
      add(1'b0,1'b1,1'b0,1'b0,32'h100,      32'h20,      4'hF, 5'd1,  1'b0,1'b0,32'h0,        32'h0,        4'h0, 5'd0);
      add(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,       4'h0, 5'd0,  1'b1,1'b0,32'h0,        32'h0,        4'h0, 5'd0);
      // streaming with out_ready high
      add(1'b1,1'b1,1'b0,1'b1,32'h100,      32'h20,      4'hF, 5'd1,  1'b1,1'b1,32'h100,      32'h120,      4'hF, 5'd1);
      add(1'b1,1'b1,1'b0,1'b1,32'h104,      32'h20,      4'h5, 5'd2,  1'b1,1'b1,32'h104,      32'h124,      4'h5, 5'd2);
      add(1'b1,1'b1,1'b0,1'b1,32'h108,      32'h20,      4'hA, 5'd3,  1'b1,1'b1,32'h108,      32'h128,      4'hA, 5'd3);
      add(1'b1,1'b1,1'b0,1'b1,32'h10C,      32'h20,      4'h6, 5'd4,  1'b1,1'b1,32'h10C,      32'h12C,      4'h6, 5'd4);
      add(1'b1,1'b0,1'b0,1'b1,32'h0,        32'h0,       4'h0, 5'd0,  1'b1,1'b0,32'h10C,      32'h12C,      4'h2, 5'd4);
      // backpressure: A accepted, B into skid, C refused, then drain in order
      add(1'b1,1'b1,1'b0,1'b0,32'h200,      32'h10,      4'hF, 5'd5,  1'b1,1'b1,32'h200,      32'h210,      4'hF, 5'd5);
      add(1'b1,1'b1,1'b0,1'b0,32'h300,      32'h10,      4'hF, 5'd6,  1'b0,1'b1,32'h200,      32'h210,      4'hF, 5'd5);
      add(1'b1,1'b1,1'b0,1'b0,32'h400,      32'h10,      4'hF, 5'd7,  1'b0,1'b1,32'h200,      32'h210,      4'hF, 5'd5);
      add(1'b1,1'b1,1'b0,1'b1,32'h400,      32'h10,      4'hF, 5'd7,  1'b1,1'b1,32'h300,      32'h310,      4'hF, 5'd6);
      add(1'b1,1'b1,1'b0,1'b1,32'h400,      32'h10,      4'hF, 5'd7,  1'b1,1'b1,32'h400,      32'h410,      4'hF, 5'd7);
      add(1'b1,1'b0,1'b0,1'b1,32'h0,        32'h0,       4'h0, 5'd0,  1'b1,1'b0,32'h400,      32'h410,      4'hA, 5'd7);
      // branch target wraps modulo 2^32
      add(1'b1,1'b1,1'b0,1'b1,32'hFFFF_FFF0,32'h20,      4'h4, 5'd8,  1'b1,1'b1,32'hFFFF_FFF0,32'h10,       4'h4, 5'd8);
      add(1'b1,1'b0,1'b0,1'b1,32'h0,        32'h0,       4'h0, 5'd0,  1'b1,1'b0,32'hFFFF_FFF0,32'h10,       4'h0, 5'd8);
      // flush in TWO, then flush dropping a live transfer from EMPTY
      add(1'b1,1'b1,1'b0,1'b0,32'h500,      32'h4,       4'hF, 5'd9,  1'b1,1'b1,32'h500,      32'h504,      4'hF, 5'd9);
      add(1'b1,1'b1,1'b0,1'b0,32'h600,      32'h4,       4'hF, 5'd10, 1'b0,1'b1,32'h500,      32'h504,      4'hF, 5'd9);
      add(1'b1,1'b1,1'b1,1'b0,32'h700,      32'h4,       4'hF, 5'd11, 1'b1,1'b0,32'h500,      32'h504,      4'hA, 5'd9);
      add(1'b1,1'b1,1'b1,1'b1,32'h800,      32'h4,       4'hF, 5'd12, 1'b1,1'b0,32'h500,      32'h504,      4'hA, 5'd9);
      add(1'b1,1'b0,1'b0,1'b1,32'h0,        32'h0,       4'h0, 5'd0,  1'b1,1'b0,32'h500,      32'h504,      4'hA, 5'd9);
      // flush together with reset: reset wins
      add(1'b1,1'b1,1'b0,1'b0,32'h900,      32'h4,       4'hF, 5'd13, 1'b1,1'b1,32'h900,      32'h904,      4'hF, 5'd13);
      add(1'b0,1'b1,1'b1,1'b0,32'h900,      32'h4,       4'hF, 5'd13, 1'b0,1'b0,32'h0,        32'h0,        4'h0, 5'd0);
      add(1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,       4'h0, 5'd0,  1'b1,1'b0,32'h0,        32'h0,        4'h0, 5'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].iv, vecs[i].fl, vecs[i].ordy, vecs[i].pc,
               vecs[i].imm, vecs[i].ctl, vecs[i].ac);
         step();
         check($sformatf("v%0d.in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vecs[i].e_ir});
         check($sformatf("v%0d.out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
         check($sformatf("v%0d.pc_q", i),      bus.pc_q,               vecs[i].e_pc);
         check($sformatf("v%0d.branch_target_q", i), bus.branch_target_q, vecs[i].e_bt);
         check($sformatf("v%0d.ctrl_q", i),    {28'd0, ctl_q()},       {28'd0, vecs[i].e_ctl});
         check($sformatf("v%0d.alu_control_q", i), {27'd0, bus.alu_control_q}, {27'd0, vecs[i].e_ac});
      end
      check("reset.rd1_q", bus.rd1_q, 32'h0);
      check("reset.rd2_q", bus.rd2_q, 32'h0);
      check("reset.imm_q", bus.imm_q, 32'h0);

      // Fill to TWO, then drain with in_valid low: exactly A then B, bounded
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA00, 32'h8, 4'hF, 5'd1);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hB00, 32'h8, 4'hF, 5'd2);
      step();
      check("fill.in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("fill.rd1_q", bus.rd1_q, 32'hA01);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 5'd0);
      for (int c = 0; c < 6 && bus.out_valid; c++) begin
         got.push_back(bus.pc_q);
         step();
      end
      check("drain.timeout", {31'd0, bus.out_valid}, 32'd0);
      check("drain.count", got.size(), 32'd2);
      check("drain.first", (got.size() > 0) ? got[0] : 32'hDEAD, 32'hA00);
      check("drain.second", (got.size() > 1) ? got[1] : 32'hDEAD, 32'hB00);

      // Reset asserted while TWO: nothing survives
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hC00, 32'h8, 4'hF, 5'd3);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hD00, 32'h8, 4'hF, 5'd4);
      step();
      check("midrst.full", {31'd0, bus.in_ready}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 5'd0);
      step();
      check("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst.pc_q", bus.pc_q, 32'h0);
      check("midrst.in_ready", {31'd0, bus.in_ready}, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 5'd0);
      step();
      check("midrst.release_ready", {31'd0, bus.in_ready}, 32'd1);
      step();
      check("midrst.no_stale", {31'd0, bus.out_valid}, 32'd0);
      check("midrst.pc_stays_0", bus.pc_q, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_skid_stage.md
ID_EX_SKID_STAGE -- requirements
Module: id_ex_skid_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc, rd1, rd2, imm, branch_target.
REQ-002 Parameter ALU_CTRL_W, default 5, ALU control width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  ID stage presents a payload.
REQ-006 in_ready  out  1  stage accepts a payload this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-007 flush  in  1  discard all held payloads (branch/exception kill).
REQ-008 mem_to_reg, mem_write, alu_src, reg_write  in  1 each  ID control bits.
REQ-009 alu_control  in  ALU_CTRL_W  ALU operation select.
REQ-010 pc, rd1, rd2, imm  in  XLEN each  PC, register operands, sign-extended immediate.
REQ-011 out_valid  out  1  EX-side payload valid.
REQ-012 out_ready  in  1  EX accepts the payload; a transfer occurs when out_valid and out_ready are both 1.
REQ-013 mem_to_reg_q, mem_write_q, alu_src_q, reg_write_q  out  1 each  registered control bits.
REQ-014 alu_control_q  out  ALU_CTRL_W;  pc_q, rd1_q, rd2_q, imm_q, branch_target_q  out  XLEN each.

Function
REQ-015 Two payload registers: MAIN (drives outputs) and SKID (overflow); state enum EMPTY, ONE, TWO.
REQ-016 EMPTY: in_valid -> load MAIN, go ONE.
REQ-017 ONE: in_valid & out_ready -> reload MAIN, stay ONE; in_valid & !out_ready -> load SKID, go TWO; !in_valid & out_ready -> EMPTY; otherwise hold.
REQ-018 TWO: out_ready -> MAIN <= SKID, go ONE; otherwise hold; no input accepted in TWO.
REQ-019 in_ready is a registered output, 1 exactly when state != TWO; no combinational path from out_ready to in_ready.
REQ-020 out_valid = 1 exactly when state != EMPTY.
REQ-021 branch_target = pc + imm modulo 2^XLEN, computed at capture and stored with the payload; carry out discarded.
REQ-022 mem_write_q and reg_write_q are forced 0 whenever out_valid = 0 (bubble is side-effect free); other outputs hold last MAIN contents.
REQ-023 Payload order is strictly FIFO; no payload is duplicated or dropped except by flush or reset.
REQ-024 flush = 1: next state EMPTY, both entries invalidated; an in_valid transfer in the same cycle is dropped; in_ready = 1 on the following cycle.
REQ-025 flush has priority over every handshake; reset has priority over flush.
REQ-026 Latency: accepted payload appears at outputs the cycle after acceptance when the stage was EMPTY or draining; throughput one payload/cycle with out_ready held 1.

Reset
REQ-027 While rst = 0 at a clock edge: state EMPTY, all outputs 0, in_ready 0.
REQ-028 First edge with rst = 1 and no other activity: in_ready = 1, out_valid = 0.
REQ-029 Reset asserted mid-operation (ONE or TWO) discards all payloads; no partial payload reaches outputs.

Structure
REQ-030 Shared package id_ex_pkg holds the state enum and default XLEN/ALU_CTRL_W constants.
REQ-031 Sub-module id_ex_payload_reg (parametrised load-enable payload register incl. branch_target) instanced twice: MAIN and SKID.

Verification
REQ-032 Reset: hold rst=0 3 cycles with in_valid=1 -> out_valid=0, all outputs 0, in_ready=0; release -> in_ready=1 next cycle.
REQ-033 Streaming: out_ready=1, 4 payloads pc=0x100,0x104,0x108,0x10C, imm=0x20 -> out 1 cycle later each, branch_target 0x120..0x12C, no gaps.
REQ-034 Backpressure: out_ready=0 after first accept, send A,B,C -> state TWO, in_ready=0, C not accepted; raise out_ready -> A then B then C, in order.
REQ-035 Wrap: pc=0xFFFF_FFF0, imm=0x0000_0020 -> branch_target_q=0x0000_0010.
REQ-036 Flush in TWO with in_valid=1 -> out_valid=0, mem_write_q=0, reg_write_q=0 next cycle, in_ready=1, incoming payload never appears.
REQ-037 Flush and rst=0 same cycle -> reset values per REQ-027.
